mp3_clkdiv_song_rom: RTL and testbench

//  Clock-divider plus song-data ROM that feeds the VS1003B MP3 serial streamer.

---
 rtl/mp3_clkdiv_song_rom_if.sv | 25 ++
 rtl/mp3_clkdiv_song_rom.sv | 78 +++++++
 tb/tb_mp3_clkdiv_song_rom.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mp3_clkdiv_song_rom_if.sv
// ROM read bus between the MP3 streamer (master) and the song ROM (slave).
interface mp3_clkdiv_song_rom_if #(
    parameter int unsigned SONG_BITS  = 5,
    parameter int unsigned WORD_BITS  = 5,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  ena;
    logic [SONG_BITS-1:0]  current;
    logic [WORD_BITS-1:0]  addr;
    logic [DATA_WIDTH-1:0] douta;

    modport master (
        output ena,
        output current,
        output addr,
        input  douta
    );

    modport slave (
        input  ena,
        input  current,
        input  addr,
        output douta
    );
endinterface

// File: rtl/mp3_clkdiv_song_rom.sv
// Clock divider (50% duty serial clock plus rise tick) and song-data ROM
// feeding the VS1003B MP3 serial streamer. The built-in ROM image is
// word[A] = A, so the contents are generated from the address.
module mp3_clkdiv_song_rom #(
    parameter int unsigned DIV_TIME   = 100,
    parameter int unsigned SONG_BITS  = 5,
    parameter int unsigned WORD_BITS  = 5,
    parameter int unsigned DATA_WIDTH = 16,
    parameter              INIT_FILE  = ""
) (
    input  logic                         clk_div,
    input  logic                         RST,
    output logic                         clk_out,
    output logic                         tick,
    mp3_clkdiv_song_rom_if.slave         rom
);
    localparam int unsigned HALF  = DIV_TIME / 2;
    localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned ADR_W = SONG_BITS + WORD_BITS;

    // Elaboration-time parameter checks.
    if (DIV_TIME < 2) begin : g_bad_div
        $error("mp3_clkdiv_song_rom: DIV_TIME must be at least 2");
    end
    if (INIT_FILE != "") begin : g_bad_image
        $error("mp3_clkdiv_song_rom: only the built-in ROM image is available");
    end

    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic                  clk_out_q, clk_out_d;
    logic                  tick_q,    tick_d;
    logic [DATA_WIDTH-1:0] douta_q,   douta_d;
    logic [ADR_W-1:0]      rom_addr_c;
    logic                  wrap_c;

    // Song select and word index are concatenated, never added.
    assign rom_addr_c = {rom.current, rom.addr};
    assign wrap_c     = (cnt_q == CNT_W'(HALF - 1));

    // Divider next state: count to HALF-1, then wrap and toggle the output.
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        if (wrap_c) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            tick_d    = ~clk_out_q;
        end
    end

    // ROM read: registered word on enable, hold otherwise.
    always_comb begin
        douta_d = douta_q;
        if (rom.ena) begin
            douta_d = DATA_WIDTH'(rom_addr_c);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_div) begin
        if (!RST) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            douta_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            douta_q   <= douta_d;
        end
    end

    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign rom.douta = douta_q;
endmodule

// File: tb/tb_mp3_clkdiv_song_rom.sv
// Directed bench for the clock divider and song ROM.
module tb_mp3_clkdiv_song_rom;
    logic clk_div;
    logic RST;
    logic clk_out;
    logic tick;

    int total;
    int bad;

    mp3_clkdiv_song_rom_if #(.SONG_BITS(5), .WORD_BITS(5), .DATA_WIDTH(16)) rom_if ();

    mp3_clkdiv_song_rom #(
        .DIV_TIME  (100),
        .SONG_BITS (5),
        .WORD_BITS (5),
        .DATA_WIDTH(16),
        .INIT_FILE ("")
    ) dut (
        .clk_div(clk_div),
        .RST    (RST),
        .clk_out(clk_out),
        .tick   (tick),
        .rom    (rom_if)
    );

    initial clk_div = 1'b0;
    always #5 clk_div = ~clk_div;

    typedef struct {
        logic        ena;
        logic [4:0]  cur;
        logic [4:0]  adr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [10];

    // Advance one rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk_div);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST        = 1'b0;
        rom_if.ena     = 1'b0;
        rom_if.current = '0;
        rom_if.addr    = '0;

        vecs[0] = '{1'b1, 5'd3,  5'd19, 16'h0073};
        vecs[1] = '{1'b1, 5'd3,  5'd0,  16'h0060};
        vecs[2] = '{1'b0, 5'd3,  5'd7,  16'h0060};
        vecs[3] = '{1'b1, 5'd3,  5'd7,  16'h0067};
        vecs[4] = '{1'b1, 5'd31, 5'd31, 16'h03FF};
        vecs[5] = '{1'b1, 5'd0,  5'd0,  16'h0000};
        vecs[6] = '{1'b1, 5'd1,  5'd2,  16'h0022};
        vecs[7] = '{1'b0, 5'd31, 5'd31, 16'h0022};
        vecs[8] = '{1'b1, 5'd16, 5'd1,  16'h0201};
        vecs[9] = '{1'b1, 5'd0,  5'd31, 16'h001F};

        // Reset held for three edges.
        repeat (3) step();
        chk("rst_clk_out", 16'(clk_out), 16'h0);
        chk("rst_tick",    16'(tick),    16'h0);
        chk("rst_douta",   rom_if.douta, 16'h0000);

        // Divider after release: high over [50,100), rise ticks at 50 and 150.
        RST = 1'b1;
        for (int n = 1; n <= 160; n++) begin
            step();
            chk($sformatf("clk_out_e%0d", n), 16'(clk_out), 16'(((n / 50) % 2) == 1));
            chk($sformatf("tick_e%0d", n),    16'(tick),    16'(n == 50 || n == 150));
        end

        // Read latency: the new address is not visible before the edge.
        rom_if.ena = 1'b1; rom_if.current = 5'd3; rom_if.addr = 5'd19;
        #1;
        chk("no_comb_read", rom_if.douta, 16'h0000);

        // Table of single-edge reads.
        for (int i = 0; i < 10; i++) begin
            rom_if.ena     = vecs[i].ena;
            rom_if.current = vecs[i].cur;
            rom_if.addr    = vecs[i].adr;
            step();
            chk($sformatf("vec%0d", i), rom_if.douta, vecs[i].exp);
        end

        // Back-to-back words 0..19 of song 3, one per edge.
        rom_if.ena = 1'b1; rom_if.current = 5'd3;
        for (int w = 0; w < 20; w++) begin
            rom_if.addr = 5'(w);
            step();
            chk($sformatf("burst_w%0d", w), rom_if.douta, 16'h0060 + 16'(w));
        end

        // Mid-operation reset while clk_out is high at count 30.
        RST = 1'b0;
        step();
        RST = 1'b1;
        rom_if.current = 5'd31; rom_if.addr = 5'd31;
        repeat (80) step();
        chk("pre_pulse_clk_out", 16'(clk_out), 16'h1);
        chk("pre_pulse_douta",   rom_if.douta, 16'h03FF);
        RST = 1'b0;
        step();
        chk("pulse_clk_out", 16'(clk_out), 16'h0);
        chk("pulse_tick",    16'(tick),    16'h0);
        chk("pulse_douta",   rom_if.douta, 16'h0000);
        RST = 1'b1;
        rom_if.ena = 1'b0;
        repeat (48) step();
        chk("post_e48_douta", rom_if.douta, 16'h0000);
        rom_if.ena = 1'b1; rom_if.current = 5'd2; rom_if.addr = 5'd5;
        step();
        chk("post_e49_clk_out", 16'(clk_out), 16'h0);
        chk("post_read",        rom_if.douta, 16'h0045);
        step();
        chk("post_e50_clk_out", 16'(clk_out), 16'h1);
        chk("post_e50_tick",    16'(tick),    16'h1);
        step();
        chk("post_e51_tick",    16'(tick),    16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
